dht11_sensor_emu: RTL and testbench

Behavioural-synthesisable emulator of the DHT11 sensor side of the single-wire bus. It is the responder counterpart to our host-side DHT11 reader.
- Detects the host start pulse on the bus, then drives the ACK and the 40-bit data frame with DHT11 timing.
- Used in FPGA loopback and simulation against the host reader block. Drives the bus open-drain style through an output-enable.

---
 rtl/dht11_pkg.sv | 24 ++
 rtl/dht11_sensor_emu_if.sv | 23 ++
 rtl/dht11_us_tick.sv | 35 +++
 rtl/dht11_sensor_emu.sv | 157 +++++++++++++++
 tb/tb_dht11_sensor_emu.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 sensor-side emulator.
package dht11_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned US_CNT_W   = 15;

  typedef enum logic [2:0] {
    IDLE,
    HOST_LOW,
    DELAY,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_e;

  // 8-bit wrapping sum of the four payload bytes.
  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
// Single-wire bus view plus payload bytes and frame status of the DHT11 emulator.
interface dht11_sensor_emu_if;
  logic       dq_in;
  logic       dq_oe;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] tmp_int;
  logic [7:0] tmp_dec;
  logic       busy;
  logic       frame_done;

  // Host / environment side: drives the wire level and payload, observes the sensor.
  modport master (
    output dq_in, hum_int, hum_dec, tmp_int, tmp_dec,
    input  dq_oe, busy, frame_done
  );

  // Sensor side.
  modport slave (
    input  dq_in, hum_int, hum_dec, tmp_int, tmp_dec,
    output dq_oe, busy, frame_done
  );
endinterface

// File: rtl/dht11_us_tick.sv
// Microsecond strobe: one-cycle pulse every CLK_PER_US cycles, phase reset by restart.
module dht11_us_tick #(
  parameter int unsigned CLK_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned   CntW    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_US - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Free-running divider; restart realigns it so the first tick lands a full us after entry.
  always_comb begin
    tick = (cnt_q == CntLast);
    if (restart || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor-side responder: detects a host start pulse, then drives ACK and a 40-bit frame.
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US    = 100,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned ACK_US        = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 27,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input logic               clk,
  input logic               rst,
  dht11_sensor_emu_if.slave bus
);

  localparam logic [US_CNT_W-1:0] StartMin   = US_CNT_W'(START_MIN_US);
  localparam logic [US_CNT_W-1:0] RespLast   = US_CNT_W'(RESP_DELAY_US - 1);
  localparam logic [US_CNT_W-1:0] AckLast    = US_CNT_W'(ACK_US - 1);
  localparam logic [US_CNT_W-1:0] BitLowLast = US_CNT_W'(BIT_LOW_US - 1);
  localparam logic [US_CNT_W-1:0] Bit0Last   = US_CNT_W'(BIT0_HIGH_US - 1);
  localparam logic [US_CNT_W-1:0] Bit1Last   = US_CNT_W'(BIT1_HIGH_US - 1);
  localparam logic [5:0]          BitIdxLast = 6'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [US_CNT_W-1:0]     us_cnt_q, us_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [5:0]              bit_idx_q, bit_idx_d;
  logic [US_CNT_W-1:0]     phase_last;
  logic                    dq_s, tick, restart, phase_done;
  logic                    dq_oe, busy, frame_done;

  assign dq_s    = sync_q[1];
  assign restart = (state_d != state_q);

  dht11_us_tick #(
    .CLK_PER_US (CLK_PER_US)
  ) u_us_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // State, synchronizer, phase counter and frame shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;  // idle wire is pulled up; avoids a false start out of reset
      us_cnt_q  <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      us_cnt_q  <= us_cnt_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Synchronizer shift and saturating microsecond counter cleared on each state entry.
  always_comb begin
    sync_d = {sync_q[0], bus.dq_in};
    if (restart) begin
      us_cnt_d = '0;
    end else if (tick && (us_cnt_q != '1)) begin
      us_cnt_d = us_cnt_q + US_CNT_W'(1);
    end else begin
      us_cnt_d = us_cnt_q;
    end
  end

  // Last microsecond index of the current timed phase.
  always_comb begin
    case (state_q)
      DELAY:             phase_last = RespLast;
      ACK_LOW, ACK_HIGH: phase_last = AckLast;
      BIT_HIGH:          phase_last = shift_q[FRAME_BITS-1] ? Bit1Last : Bit0Last;
      default:           phase_last = BitLowLast;
    endcase
  end

  assign phase_done = tick && (us_cnt_q == phase_last);

  // Next-state logic; the wire is ignored once the sensor starts driving.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (!dq_s) state_d = HOST_LOW;
      end
      HOST_LOW: begin
        if (dq_s) begin
          if (us_cnt_q >= StartMin) begin
            state_d = DELAY;
            shift_d = {bus.hum_int, bus.hum_dec, bus.tmp_int, bus.tmp_dec,
                       checksum(bus.hum_int, bus.hum_dec, bus.tmp_int, bus.tmp_dec)};
          end else begin
            state_d = IDLE;
          end
        end
      end
      DELAY: begin
        if (!dq_s)           state_d = HOST_LOW;
        else if (phase_done) state_d = ACK_LOW;
      end
      ACK_LOW: begin
        if (phase_done) state_d = ACK_HIGH;
      end
      ACK_HIGH: begin
        if (phase_done) begin
          state_d   = BIT_LOW;
          bit_idx_d = '0;
        end
      end
      BIT_LOW: begin
        if (phase_done) state_d = BIT_HIGH;
      end
      BIT_HIGH: begin
        if (phase_done) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == BitIdxLast) ? END_LOW : BIT_LOW;
        end
      end
      END_LOW: begin
        if (phase_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    dq_oe      = 1'b0;
    frame_done = 1'b0;
    busy       = !(state_q inside {IDLE, HOST_LOW});
    case (state_q)
      ACK_LOW, BIT_LOW: dq_oe = 1'b1;
      END_LOW: begin
        dq_oe      = 1'b1;
        frame_done = phase_done;
      end
      default: dq_oe = 1'b0;
    endcase
  end

  assign bus.dq_oe      = dq_oe;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Directed bench for the DHT11 emulator at 2 clk/us with a 100 us start threshold.
module tb_dht11_sensor_emu;
  import dht11_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_pulses;
  logic done_oe;

  dht11_sensor_emu_if ifc ();

  dht11_sensor_emu #(
    .CLK_PER_US   (2),
    .START_MIN_US (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-done pulse counter; also records whether the bus was still held low at the pulse.
  always @(negedge clk) begin
    if (ifc.frame_done === 1'b1) begin
      done_pulses++;
      done_oe = ifc.dq_oe;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles dq_oe holds lvl, starting at the current falling edge.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (ifc.dq_oe === lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    ifc.hum_int = a;
    ifc.hum_dec = b;
    ifc.tmp_int = c;
    ifc.tmp_dec = d;
  endtask

  task automatic host_start(input int low_us);
    @(negedge clk);
    ifc.dq_in = 1'b0;
    repeat (low_us * 2) @(negedge clk);
    ifc.dq_in = 1'b1;
  endtask

  // Called right after host release; times every phase and decodes the 40 bits.
  task automatic run_frame(input string tag, input logic [39:0] exp);
    int n;
    logic [39:0] got;
    got = '0;
    done_pulses = 0;
    done_oe = 1'b0;
    n = 0;
    while (ifc.dq_oe !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    // 2 sync + 1 FSM cycle, then 30 us
    check({tag, "_resp_delay"}, n, 63);
    check({tag, "_busy_ack"}, ifc.busy, 1'b1);
    // payload changes after acceptance must not leak into the frame
    set_bytes(~ifc.hum_int, ~ifc.hum_dec, ~ifc.tmp_int, ~ifc.tmp_dec);
    measure(1'b1, n);
    check({tag, "_ack_low"}, n, 160);
    measure(1'b0, n);
    check({tag, "_ack_high"}, n, 160);
    for (int i = 0; i < 40; i++) begin
      measure(1'b1, n);
      check($sformatf("%s_bit%0d_low", tag, i), n, 100);
      measure(1'b0, n);
      check($sformatf("%s_bit%0d_high", tag, i), n, exp[39-i] ? 140 : 54);
      got[39-i] = (n > 97);
    end
    measure(1'b1, n);
    check({tag, "_end_low"}, n, 100);
    check({tag, "_data"}, got, exp);
    check({tag, "_done_pulses"}, done_pulses, 1);
    check({tag, "_done_in_end_low"}, done_oe, 1'b1);
    check({tag, "_busy_after"}, ifc.busy, 1'b0);
  endtask

  initial begin
    int n;
    int hits;
    int rises;
    logic prev;
    checks      = 0;
    failures    = 0;
    done_pulses = 0;
    done_oe     = 1'b0;
    rst         = 1'b1;
    ifc.dq_in   = 1'b1;
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dq_oe", ifc.dq_oe, 1'b0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_frame_done", ifc.frame_done, 1'b0);
    check("rst_state", dut.state_q, IDLE);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Typical reading, checksum 0x55
    host_start(150);
    run_frame("f1", 40'h37_00_19_05_55);

    // All-ones payload, checksum wraps to 0xFC
    repeat (20) @(negedge clk);
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    host_start(150);
    run_frame("f2", 40'hFF_FF_FF_FF_FC);

    // Runt low pulse below the start threshold
    repeat (20) @(negedge clk);
    host_start(60);
    @(negedge clk);
    @(negedge clk);
    check("runt_host_low", dut.state_q, HOST_LOW);
    @(negedge clk);
    check("runt_idle", dut.state_q, IDLE);
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.dq_oe !== 1'b0 || ifc.busy !== 1'b0) hits++;
    end
    check("runt_quiet", hits, 0);

    // Host pulls low again during the response delay
    set_bytes(8'hA5, 8'h5A, 8'h01, 8'h02);
    host_start(150);
    repeat (20) @(negedge clk);
    check("restart_busy_delay", ifc.busy, 1'b1);
    ifc.dq_in = 1'b0;
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifc.dq_oe !== 1'b0) hits++;
    end
    check("restart_no_ack", hits, 0);
    check("restart_busy_low", ifc.busy, 1'b0);
    ifc.dq_in = 1'b1;
    run_frame("f3", 40'hA5_5A_01_02_02);

    // Reset during bit 20, then a clean frame
    repeat (20) @(negedge clk);
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    host_start(150);
    rises = 0;
    n = 0;
    prev = ifc.dq_oe;
    while (rises < 22 && n < 20000) begin
      @(negedge clk);
      n++;
      if (ifc.dq_oe === 1'b1 && prev === 1'b0) rises++;
      prev = ifc.dq_oe;
    end
    check("bit20_reached", rises, 22);
    repeat (10) @(negedge clk);
    check("bit20_driving", ifc.dq_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dq_oe", ifc.dq_oe, 1'b0);
    check("midrst_busy", ifc.busy, 1'b0);
    check("midrst_state", dut.state_q, IDLE);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
    host_start(150);
    run_frame("f4", 40'h12_34_56_78_14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
